// File: rtl/axi_xbar_pkg.sv
// Shared types and response codes for the AXI4-Lite 1-to-2 crossbar.
package axi_xbar_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FWD,
        R_WAIT,
        R_ERR
    } rd_state_t;

    typedef enum logic [1:0] {
        W_COLLECT,
        W_FWD,
        W_RESP,
        W_ERR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        TGT_MEM,
        TGT_CLINT,
        TGT_NONE
    } tgt_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational address-window decoder: memory window, CLINT window or unmapped.
module axi_lite_addr_decode
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000,
    parameter logic [31:0] CLINT_BASE = 32'h0a00_0048,
    parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
    input  logic [31:0] addr,
    output tgt_t        tgt
);

    logic [31:0] off0;
    logic [31:0] off1;
    logic        hit0;
    logic        hit1;

    // Window hit tests; the CLINT window wins when both windows match.
    always_comb begin
        off0 = addr - MEM_BASE;
        off1 = addr - CLINT_BASE;
        hit0 = (addr >= MEM_BASE) && (off0 < MEM_SIZE);
        hit1 = (addr >= CLINT_BASE) && (off1 < CLINT_SIZE);
        if (hit1) begin
            tgt = TGT_CLINT;
        end else if (hit0) begin
            tgt = TGT_MEM;
        end else begin
            tgt = TGT_NONE;
        end
    end

endmodule

// File: rtl/axi_lite_xbar_1to2.sv
// AXI4-Lite router: one master to memory (s0) and CLINT (s1), DECERR for unmapped.
// Addresses are latched and held on both slaves until the response completes.
module axi_lite_xbar_1to2
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE   = 32'h0800_0000,
    parameter logic [31:0] CLINT_BASE = 32'h0a00_0048,
    parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        reset,
    // upstream master
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_awaddr,
    input  logic        m_wvalid,
    output logic        m_wready,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic        m_bvalid,
    input  logic        m_bready,
    output logic [1:0]  m_bresp,
    input  logic        m_arvalid,
    output logic        m_arready,
    input  logic [31:0] m_araddr,
    output logic        m_rvalid,
    input  logic        m_rready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    // slave 0: memory
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_awaddr,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    input  logic [1:0]  s0_bresp,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    output logic [31:0] s0_araddr,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    // slave 1: CLINT
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_awaddr,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,
    input  logic        s1_bvalid,
    output logic        s1_bready,
    input  logic [1:0]  s1_bresp,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    output logic [31:0] s1_araddr,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp
);

    tgt_t ar_tgt;
    tgt_t aw_tgt;

    axi_lite_addr_decode #(
        .MEM_BASE  (MEM_BASE),
        .MEM_SIZE  (MEM_SIZE),
        .CLINT_BASE(CLINT_BASE),
        .CLINT_SIZE(CLINT_SIZE)
    ) u_ar_decode (
        .addr(m_araddr),
        .tgt (ar_tgt)
    );

    axi_lite_addr_decode #(
        .MEM_BASE  (MEM_BASE),
        .MEM_SIZE  (MEM_SIZE),
        .CLINT_BASE(CLINT_BASE),
        .CLINT_SIZE(CLINT_SIZE)
    ) u_aw_decode (
        .addr(m_awaddr),
        .tgt (aw_tgt)
    );

    // ---------------- read path ----------------
    rd_state_t   rd_q, rd_d;
    logic [31:0] araddr_q, araddr_d;
    tgt_t        rtgt_q, rtgt_d;
    logic        rsel_clint;
    logic        sel_arready;

    assign s0_araddr = araddr_q;
    assign s1_araddr = araddr_q;

    // Read FSM state and address/target latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q     <= R_IDLE;
            araddr_q <= '0;
            rtgt_q   <= TGT_NONE;
        end else begin
            rd_q     <= rd_d;
            araddr_q <= araddr_d;
            rtgt_q   <= rtgt_d;
        end
    end

    // Read next-state and channel steering to the selected slave.
    always_comb begin
        rd_d        = rd_q;
        araddr_d    = araddr_q;
        rtgt_d      = rtgt_q;
        m_arready   = 1'b0;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
        m_rresp     = RESP_OKAY;
        s0_arvalid  = 1'b0;
        s1_arvalid  = 1'b0;
        s0_rready   = 1'b0;
        s1_rready   = 1'b0;
        rsel_clint  = (rtgt_q == TGT_CLINT);
        sel_arready = rsel_clint ? s1_arready : s0_arready;
        case (rd_q)
            R_IDLE: begin
                m_arready = 1'b1;
                if (m_arvalid) begin
                    araddr_d = m_araddr;
                    rtgt_d   = ar_tgt;
                    rd_d     = (ar_tgt == TGT_NONE) ? R_ERR : R_FWD;
                end
            end
            R_FWD: begin
                s0_arvalid = !rsel_clint;
                s1_arvalid = rsel_clint;
                if (sel_arready) begin
                    rd_d = R_WAIT;
                end
            end
            R_WAIT: begin
                m_rvalid  = rsel_clint ? s1_rvalid : s0_rvalid;
                m_rdata   = rsel_clint ? s1_rdata  : s0_rdata;
                m_rresp   = rsel_clint ? s1_rresp  : s0_rresp;
                s0_rready = !rsel_clint && m_rready;
                s1_rready = rsel_clint && m_rready;
                if (m_rvalid && m_rready) begin
                    rd_d = R_IDLE;
                end
            end
            R_ERR: begin
                m_rvalid = 1'b1;
                m_rresp  = RESP_DECERR;
                if (m_rready) begin
                    rd_d = R_IDLE;
                end
            end
            default: rd_d = R_IDLE;
        endcase
    end

    // ---------------- write path ----------------
    wr_state_t   wr_q, wr_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    tgt_t        wtgt_q, wtgt_d;
    logic        aw_have_q, aw_have_d;
    logic        w_have_q, w_have_d;
    logic        aw_sent_q, aw_sent_d;
    logic        w_sent_q, w_sent_d;
    logic        wsel_clint;
    logic        sel_awready;
    logic        sel_wready;

    assign s0_awaddr = awaddr_q;
    assign s1_awaddr = awaddr_q;
    assign s0_wdata  = wdata_q;
    assign s1_wdata  = wdata_q;
    assign s0_wstrb  = wstrb_q;
    assign s1_wstrb  = wstrb_q;

    // Write FSM state, payload latches and handshake flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q      <= W_COLLECT;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wtgt_q    <= TGT_NONE;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            aw_sent_q <= 1'b0;
            w_sent_q  <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wtgt_q    <= wtgt_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            aw_sent_q <= aw_sent_d;
            w_sent_q  <= w_sent_d;
        end
    end

    // Write next-state: collect AW/W in any order, forward, then return B.
    always_comb begin
        wr_d        = wr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wtgt_d      = wtgt_q;
        aw_have_d   = aw_have_q;
        w_have_d    = w_have_q;
        aw_sent_d   = aw_sent_q;
        w_sent_d    = w_sent_q;
        m_awready   = 1'b0;
        m_wready    = 1'b0;
        m_bvalid    = 1'b0;
        m_bresp     = RESP_OKAY;
        s0_awvalid  = 1'b0;
        s1_awvalid  = 1'b0;
        s0_wvalid   = 1'b0;
        s1_wvalid   = 1'b0;
        s0_bready   = 1'b0;
        s1_bready   = 1'b0;
        wsel_clint  = (wtgt_q == TGT_CLINT);
        sel_awready = wsel_clint ? s1_awready : s0_awready;
        sel_wready  = wsel_clint ? s1_wready  : s0_wready;
        case (wr_q)
            W_COLLECT: begin
                m_awready = !aw_have_q;
                m_wready  = !w_have_q;
                if (m_awvalid && m_awready) begin
                    aw_have_d = 1'b1;
                    awaddr_d  = m_awaddr;
                    wtgt_d    = aw_tgt;
                end
                if (m_wvalid && m_wready) begin
                    w_have_d = 1'b1;
                    wdata_d  = m_wdata;
                    wstrb_d  = m_wstrb;
                end
                // Looks at the next-cycle flags so a same-cycle AW+W pair moves on at once.
                if (aw_have_d && w_have_d) begin
                    wr_d = (wtgt_d == TGT_NONE) ? W_ERR_RESP : W_FWD;
                end
            end
            W_FWD: begin
                s0_awvalid = !wsel_clint && !aw_sent_q;
                s1_awvalid = wsel_clint && !aw_sent_q;
                s0_wvalid  = !wsel_clint && !w_sent_q;
                s1_wvalid  = wsel_clint && !w_sent_q;
                if (!aw_sent_q && sel_awready) begin
                    aw_sent_d = 1'b1;
                end
                if (!w_sent_q && sel_wready) begin
                    w_sent_d = 1'b1;
                end
                if (aw_sent_d && w_sent_d) begin
                    wr_d = W_RESP;
                end
            end
            W_RESP: begin
                m_bvalid  = wsel_clint ? s1_bvalid : s0_bvalid;
                m_bresp   = wsel_clint ? s1_bresp  : s0_bresp;
                s0_bready = !wsel_clint && m_bready;
                s1_bready = wsel_clint && m_bready;
                if (m_bvalid && m_bready) begin
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    aw_sent_d = 1'b0;
                    w_sent_d  = 1'b0;
                    wr_d      = W_COLLECT;
                end
            end
            W_ERR_RESP: begin
                m_bvalid = 1'b1;
                m_bresp  = RESP_DECERR;
                if (m_bready) begin
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    aw_sent_d = 1'b0;
                    w_sent_d  = 1'b0;
                    wr_d      = W_COLLECT;
                end
            end
            default: wr_d = W_COLLECT;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_xbar_1to2.sv
// Directed bench for axi_lite_xbar_1to2 with behavioural memory and CLINT slaves.
module tb_axi_lite_xbar_1to2;

    localparam logic [31:0] MTIME_LO = 32'h1122_3344;
    localparam logic [31:0] MTIME_HI = 32'h5566_7788;

    logic        clk;
    logic        reset;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
    logic [3:0]  s0_wstrb;
    logic [1:0]  s0_bresp, s0_rresp;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
    logic [3:0]  s1_wstrb;
    logic [1:0]  s1_bresp, s1_rresp;

    int vectors = 0;
    int errs    = 0;

    axi_lite_xbar_1to2 #(
        .MEM_BASE  (32'h8000_0000),
        .MEM_SIZE  (32'h0800_0000),
        .CLINT_BASE(32'h0a00_0048),
        .CLINT_SIZE(32'h0000_0008)
    ) dut (
        .clk(clk), .reset(reset),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave 0: memory model ----------------
    int          s0_rlat = 0;
    logic        s0_aw_block = 1'b0;
    logic        s0_rbusy, s0_awgot, s0_wgot;
    int          s0_rcnt;
    logic [31:0] s0_raddr_lat, s0_last_awaddr, s0_last_wdata;
    logic [3:0]  s0_last_wstrb;
    logic [31:0] mem [16];
    int          s0_arv_cyc = 0;
    int          s0_aw_hs = 0;

    assign s0_arready = !s0_rbusy;
    assign s0_awready = !s0_awgot && !s0_aw_block;
    assign s0_wready  = !s0_wgot;
    assign s0_rdata   = mem[s0_raddr_lat[5:2]];
    assign s0_rresp   = 2'b00;
    assign s0_bresp   = 2'b00;

    // Memory slave: AR/R with programmable latency, AW/W in any order, B after both.
    always @(posedge clk) begin
        if (reset) begin
            s0_rbusy <= 1'b0; s0_rvalid <= 1'b0; s0_rcnt <= 0; s0_raddr_lat <= '0;
            s0_awgot <= 1'b0; s0_wgot <= 1'b0; s0_bvalid <= 1'b0;
            s0_last_awaddr <= '0; s0_last_wdata <= '0; s0_last_wstrb <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'hc0de_0000 + 32'(i);
        end else begin
            if (s0_arvalid) s0_arv_cyc <= s0_arv_cyc + 1;
            if (s0_arvalid && s0_arready) begin
                s0_rbusy <= 1'b1; s0_rcnt <= s0_rlat; s0_raddr_lat <= s0_araddr;
            end else if (s0_rbusy && !s0_rvalid) begin
                if (s0_rcnt == 0) s0_rvalid <= 1'b1;
                else s0_rcnt <= s0_rcnt - 1;
            end
            if (s0_rvalid && s0_rready) begin
                s0_rvalid <= 1'b0; s0_rbusy <= 1'b0;
            end
            if (s0_awvalid && s0_awready) begin
                s0_awgot <= 1'b1; s0_last_awaddr <= s0_awaddr; s0_aw_hs <= s0_aw_hs + 1;
            end
            if (s0_wvalid && s0_wready) begin
                s0_wgot <= 1'b1; s0_last_wdata <= s0_wdata; s0_last_wstrb <= s0_wstrb;
            end
            if (s0_awgot && s0_wgot && !s0_bvalid) s0_bvalid <= 1'b1;
            if (s0_bvalid && s0_bready) begin
                s0_bvalid <= 1'b0; s0_awgot <= 1'b0; s0_wgot <= 1'b0;
                for (int b = 0; b < 4; b++)
                    if (s0_last_wstrb[b]) mem[s0_last_awaddr[5:2]][b*8 +: 8] <= s0_last_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- slave 1: CLINT model ----------------
    int          s1_rlat = 0;
    logic        s1_rbusy, s1_awgot, s1_wgot;
    int          s1_rcnt;
    logic [31:0] s1_raddr_lat, s1_last_awaddr, s1_last_wdata;
    int          s1_arv_cyc = 0;
    int          s1_aw_hs = 0;
    int          s1_glitch = 0;

    assign s1_arready = !s1_rbusy;
    assign s1_awready = !s1_awgot;
    assign s1_wready  = !s1_wgot;
    // Return data follows araddr live during R, so a moving address corrupts it.
    assign s1_rdata   = (s1_araddr == 32'h0a00_0048) ? MTIME_LO :
                        (s1_araddr == 32'h0a00_004c) ? MTIME_HI : 32'hbad0_bad0;
    assign s1_rresp   = 2'b00;
    assign s1_bresp   = 2'b10;

    // CLINT slave: reads decode araddr during R; every write answers SLVERR.
    always @(posedge clk) begin
        if (reset) begin
            s1_rbusy <= 1'b0; s1_rvalid <= 1'b0; s1_rcnt <= 0; s1_raddr_lat <= '0;
            s1_awgot <= 1'b0; s1_wgot <= 1'b0; s1_bvalid <= 1'b0;
            s1_last_awaddr <= '0; s1_last_wdata <= '0;
        end else begin
            if (s1_arvalid) s1_arv_cyc <= s1_arv_cyc + 1;
            if (s1_rbusy && s1_araddr !== s1_raddr_lat) s1_glitch <= s1_glitch + 1;
            if (s1_arvalid && s1_arready) begin
                s1_rbusy <= 1'b1; s1_rcnt <= s1_rlat; s1_raddr_lat <= s1_araddr;
            end else if (s1_rbusy && !s1_rvalid) begin
                if (s1_rcnt == 0) s1_rvalid <= 1'b1;
                else s1_rcnt <= s1_rcnt - 1;
            end
            if (s1_rvalid && s1_rready) begin
                s1_rvalid <= 1'b0; s1_rbusy <= 1'b0;
            end
            if (s1_awvalid && s1_awready) begin
                s1_awgot <= 1'b1; s1_last_awaddr <= s1_awaddr; s1_aw_hs <= s1_aw_hs + 1;
            end
            if (s1_wvalid && s1_wready) begin
                s1_wgot <= 1'b1; s1_last_wdata <= s1_wdata;
            end
            if (s1_awgot && s1_wgot && !s1_bvalid) s1_bvalid <= 1'b1;
            if (s1_bvalid && s1_bready) begin
                s1_bvalid <= 1'b0; s1_awgot <= 1'b0; s1_wgot <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issue one read; check latency from AR accept to rvalid, hold stability, data and resp.
    task automatic read_chk(input string tag, input logic [31:0] addr, input int hold,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input int exp_lat);
        int n;
        m_araddr = addr; m_arvalid = 1'b1; m_rready = 1'b0;
        n = 0;
        while (!m_arready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_arready"}, 32'(m_arready), 32'd1);
        @(negedge clk);
        m_arvalid = 1'b0;
        n = 1;
        while (!m_rvalid && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_rvalid"}, 32'(m_rvalid), 32'd1);
            chk({tag, "_hold_rdata"}, m_rdata, exp_data);
            @(negedge clk);
        end
        chk({tag, "_rdata"}, m_rdata, exp_data);
        chk({tag, "_rresp"}, 32'(m_rresp), 32'(exp_resp));
        m_rready = 1'b1;
        @(negedge clk);
        m_rready = 1'b0;
    endtask

    // Issue one write with W leading AW by w_lead cycles; check the B response.
    task automatic write_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input logic [1:0] exp_resp);
        bit aw_pend, w_pend, will_aw, will_w;
        int k;
        aw_pend = 1'b1; w_pend = 1'b1; k = 0;
        m_awaddr = addr; m_wdata = data; m_wstrb = strb;
        while ((aw_pend || w_pend) && k < 60) begin
            m_awvalid = aw_pend && (k >= w_lead);
            m_wvalid  = w_pend;
            will_aw   = m_awvalid && m_awready;
            will_w    = m_wvalid && m_wready;
            @(negedge clk);
            if (will_aw) aw_pend = 1'b0;
            if (will_w) w_pend = 1'b0;
            k++;
        end
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        chk({tag, "_accepted"}, 32'(aw_pend || w_pend), 32'd0);
        m_bready = 1'b1;
        k = 0;
        while (!m_bvalid && k < 50) begin @(negedge clk); k++; end
        chk({tag, "_bvalid"}, 32'(m_bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(m_bresp), 32'(exp_resp));
        @(negedge clk);
        m_bready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int a0, a1;

    initial begin
        reset = 1'b1;
        m_awvalid = 1'b0; m_awaddr = '0; m_wvalid = 1'b0; m_wdata = '0; m_wstrb = '0;
        m_bready = 1'b0; m_arvalid = 1'b0; m_araddr = '0; m_rready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_arready", 32'(m_arready), 32'd1);
        chk("rst_awready", 32'(m_awready), 32'd1);
        chk("rst_wready", 32'(m_wready), 32'd1);
        chk("rst_rvalid", 32'(m_rvalid), 32'd0);
        chk("rst_bvalid", 32'(m_bvalid), 32'd0);
        repeat (100) @(negedge clk);

        // 1: CLINT mtime lo with slave latency, address must not move during R
        s1_rlat = 2;
        a0 = s0_arv_cyc;
        read_chk("t1", 32'h0a00_0048, 1, MTIME_LO, 2'b00, 5);
        chk("t1_s1_addr_glitch", 32'(s1_glitch), 32'd0);
        chk("t1_s0_arvalid", 32'(s0_arv_cyc - a0), 32'd0);
        s1_rlat = 0;

        // 2: memory read with master holding rready low for 5 cycles
        s0_rlat = 1;
        a1 = s1_arv_cyc;
        read_chk("t2", 32'h8000_0100, 5, 32'hc0de_0000, 2'b00, 4);
        chk("t2_s1_arvalid", 32'(s1_arv_cyc - a1), 32'd0);
        s0_rlat = 0;

        // 3: unmapped read -> DECERR one cycle after accept, no slave traffic
        a0 = s0_arv_cyc; a1 = s1_arv_cyc;
        read_chk("t3", 32'h0000_1000, 2, 32'h0, 2'b11, 1);
        chk("t3_s0_arvalid", 32'(s0_arv_cyc - a0), 32'd0);
        chk("t3_s1_arvalid", 32'(s1_arv_cyc - a1), 32'd0);

        // Window boundaries
        read_chk("b_mem_last", 32'h87ff_fffc, 0, 32'hc0de_000f, 2'b00, 3);
        read_chk("b_mem_end", 32'h8800_0000, 0, 32'h0, 2'b11, 1);
        read_chk("b_mem_below", 32'h7fff_fffc, 0, 32'h0, 2'b11, 1);
        read_chk("b_clint_hi", 32'h0a00_004c, 0, MTIME_HI, 2'b00, 3);
        read_chk("b_clint_end", 32'h0a00_0050, 0, 32'h0, 2'b11, 1);
        read_chk("b_clint_below", 32'h0a00_0044, 0, 32'h0, 2'b11, 1);

        // 4: W three cycles ahead of AW to CLINT, SLVERR passes through
        write_chk("t4", 32'h0a00_004c, 32'h0000_0001, 4'hf, 3, 2'b10);
        chk("t4_s1_awaddr", s1_last_awaddr, 32'h0a00_004c);
        chk("t4_s1_wdata", s1_last_wdata, 32'h0000_0001);

        // Unmapped write -> DECERR, neither slave sees AW
        a0 = s0_aw_hs; a1 = s1_aw_hs;
        write_chk("w_unmapped", 32'h0000_0010, 32'h1234_5678, 4'hf, 0, 2'b11);
        chk("w_unmapped_s0", 32'(s0_aw_hs - a0), 32'd0);
        chk("w_unmapped_s1", 32'(s1_aw_hs - a1), 32'd0);

        // 5: concurrent memory write and CLINT read
        fork
            write_chk("t5w", 32'h8000_0000, 32'hdead_beef, 4'hf, 0, 2'b00);
            read_chk("t5r", 32'h0a00_0048, 0, MTIME_LO, 2'b00, 3);
        join
        chk("t5_s0_awaddr", s0_last_awaddr, 32'h8000_0000);
        chk("t5_s0_wdata", s0_last_wdata, 32'hdead_beef);
        chk("t5_s0_wstrb", 32'(s0_last_wstrb), 32'hf);
        read_chk("t5_readback", 32'h8000_0000, 0, 32'hdead_beef, 2'b00, 3);

        // Partial strobe write on memory word 1
        write_chk("strb", 32'h8000_0004, 32'h1122_3344, 4'h3, 1, 2'b00);
        chk("strb_wstrb", 32'(s0_last_wstrb), 32'h3);
        read_chk("strb_readback", 32'h8000_0004, 0, 32'hc0de_3344, 2'b00, 3);

        // 6: reset while read is in R_WAIT and write is stuck in W_FWD
        s0_rlat = 20; s0_aw_block = 1'b1;
        m_araddr = 32'h8000_0004; m_arvalid = 1'b1;
        m_awaddr = 32'h8000_0008; m_awvalid = 1'b1;
        m_wdata = 32'h5555_aaaa; m_wstrb = 4'hf; m_wvalid = 1'b1;
        @(negedge clk);
        m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_pre_awvalid", 32'(s0_awvalid), 32'd1);
        chk("t6_pre_rvalid", 32'(m_rvalid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_valids", 32'({m_rvalid, m_bvalid, s0_arvalid, s0_awvalid, s0_wvalid,
                              s0_rready, s0_bready, s1_arvalid, s1_awvalid, s1_wvalid,
                              s1_rready, s1_bready}), 32'd0);
        chk("t6_readies", 32'({m_arready, m_awready, m_wready}), 32'd7);
        reset = 1'b0; s0_rlat = 0; s0_aw_block = 1'b0;
        @(negedge clk);
        read_chk("t6_after", 32'h8000_0004, 0, 32'hc0de_0001, 2'b00, 3);
        chk("t6_no_bvalid", 32'(m_bvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
